// File: rtl/seq_mult_if.sv
// seq_mult_if: start/done handshake and operand/result bundle for seq_mult.
//
// Parameters:
//   WIDTH   operand width; product is 2*WIDTH bits
//
// Signals:
//   start    request a multiply (controller -> multiplier)
//   a, b     multiplicand / multiplier, captured when start is accepted
//   tc       two's-complement select, sampled with start
//            (only when SEQ_MULT_SIGNED_EN is defined)
//   busy     operation in progress (multiplier -> controller)
//   done     one-cycle pulse: product just updated
//   product  last completed result
//
// Modports: master = operation controller, slave = seq_mult.
interface seq_mult_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 tc;

  modport master (output start, a, b, tc, input busy, done, product);
  modport slave  (input start, a, b, tc, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif
endinterface

// File: rtl/seq_mult.sv
// seq_mult: sequential shift-add multiplier, one partial product per cycle.
//
// The full 2*WIDTH-bit product of two WIDTH-bit operands is built over
// WIDTH RUN cycles with a single WIDTH+1-bit adder.  Start is accepted in
// IDLE and in DONE (back-to-back); it is ignored while busy.
//
// Parameters:
//   WIDTH   operand width, 2..32
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     seq_mult_if.slave: start, a, b, (tc), busy, done, product
//
// Optional feature: define SEQ_MULT_SIGNED_EN to add bus.tc.  With tc=1 the
// operands are two's complement and the product is the exact signed result;
// latency is the same in both modes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one add/shift per cycle, WIDTH cycles, busy=1
// DONE  | one cycle, done=1, product just loaded; start re-accepted
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mult;
  logic [WIDTH-1:0]     acc;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   product_r;
  logic                 signed_mode;

  logic                 accept;
  logic                 last;
  logic                 busy_c;
  logic                 done_c;
  logic [WIDTH:0]       acc_sx;
  logic [WIDTH:0]       addend;
  logic [WIDTH:0]       acc_ext;
  logic [WIDTH-1:0]     acc_shift;
  logic [WIDTH-1:0]     mult_shift;

`ifdef SEQ_MULT_SIGNED_EN
  logic                 tc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_r <= 1'b0;
    end else if (accept) begin
      tc_r <= bus.tc;
    end
  end

  assign signed_mode = tc_r;
`else
  assign signed_mode = 1'b0;
`endif

  assign accept = bus.start && ((state == IDLE) || (state == DONE));
  assign last   = (count == LAST);

  // One add/shift step.  In unsigned mode both terms are zero-extended and
  // the carry lands in acc_ext[WIDTH].  In signed mode both are
  // sign-extended, and the multiplier MSB (weight -2^(WIDTH-1)) is handled
  // by subtracting on the final iteration; dropping acc_ext[0] into mult is
  // then an arithmetic shift of the whole {acc, mult} pair.
  always_comb begin
    acc_sx = {signed_mode & acc[WIDTH-1], acc};
    addend = {signed_mode & mcand[WIDTH-1], mcand};
    if (!mult[0]) begin
      acc_ext = acc_sx;
    end else if (signed_mode && last) begin
      acc_ext = acc_sx - addend;
    end else begin
      acc_ext = acc_sx + addend;
    end
    acc_shift  = acc_ext[WIDTH:1];
    mult_shift = {acc_ext[0], mult[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // product_r is only written on the final RUN edge, so it never exposes
  // partial sums and holds its value until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mult      <= '0;
      acc       <= '0;
      count     <= '0;
      product_r <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      mult  <= bus.b;
      acc   <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= acc_shift;
      mult  <= mult_shift;
      count <= count + CW'(1);
      if (last) begin
        product_r <= {acc_shift, mult_shift};
      end
    end
  end

  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.product = product_r;

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier; successor to the 4-bit combinational array multiplier.
- Produces the full 2*WIDTH-bit product of two WIDTH-bit operands over WIDTH clock cycles.
- Uses a single WIDTH+1-bit adder instead of WIDTH-1 adder stages.
- Sits in the calculator datapath beside the adder/subtractor; the operation controller drives it through a start/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled on rising clk
- a  input  WIDTH  multiplicand; captured on start acceptance
- b  input  WIDTH  multiplier; captured on start acceptance
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse: product just updated
- product  output  2*WIDTH  result register; holds last result

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous-safe deassert):
  - state=IDLE; busy=0; done=0; product=0.
  - Internal accumulator, multiplier shift register and cycle counter cleared.
- States: IDLE, RUN, DONE. Counter width is clog2(WIDTH)+1.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: capture a into the multiplicand register and b into the multiplier shift register; clear acc and count; go to RUN.
- RUN:
  - busy=1.
  - Each edge: if the multiplier LSB is 1, acc_ext = acc + multiplicand (WIDTH+1 bits, carry kept); otherwise acc_ext = acc.
  - Shift {acc_ext, mult} right by one; count++.
  - On the edge where count reaches WIDTH: load product={acc,mult}; go to DONE.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0.
  - start=1 at the edge leaving DONE is accepted (back-to-back): goes to RUN with new operands. Otherwise goes to IDLE.
- Latency:
  - start sampled at edge E0 → done high and product valid after edge E0+WIDTH.
  - Throughput: one result per WIDTH+1 cycles.
- start while busy=1 is ignored: no operand capture, no effect on the in-flight result.
- Operands are not re-sampled after capture; a and b may change freely during RUN.
- product holds its value until the next completion. It never changes during RUN, and never shows partial sums.
- No early termination: zero operands still take WIDTH cycles.
- Arithmetic:
  - Unsigned, exact. No overflow is possible: max (2^W-1)^2 < 2^(2W).
  - The carry out of each add enters acc MSB on the shift; it is never dropped.
- Reset mid-operation aborts immediately: outputs return to reset values and the operation is lost.
- done is never high in the same cycle as busy.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN
- Defined:
  - Adds input port tc (1 bit), sampled together with start.
  - tc=1: a and b are two's complement; product is the exact signed 2*WIDTH-bit result. Implementation choice is free (radix-2 Booth, or a subtract on the final iteration with arithmetic shift).
  - tc=0: unsigned, as above.
  - Latency is identical in both modes.
- Undefined: port tc does not exist; unsigned only.

Test Plan:
- WIDTH=4, a=15, b=15, single start pulse → busy for 4 cycles; done pulses once 4 edges after the start edge; product=8'hE1; product stays 8'hE1 afterwards.
- WIDTH=8: pairs (0,255), (255,255), (1,200), (128,2) → product 16'h0000, 16'hFE01, 16'h00C8, 16'h0100; each takes exactly 8 RUN cycles.
- WIDTH=8: start 3*5, then start again on cycle 3 with 7*7 → second start ignored; product=15. Then start held high through DONE with 9*9 → back-to-back accept; next result 81; exactly one done pulse per operation.
- WIDTH=8: start 200*200, drop rst_n at RUN cycle 4 → busy, done and product go to 0 asynchronously. After release, 6*7 → product=42.
- SEQ_MULT_SIGNED_EN, WIDTH=4:
  - tc=1, -8*7 → 8'hC8.
  - tc=1, -8*-8 → 8'h40.
  - tc=0, 8*7 → 8'h38.
  - Same latency in all three cases.
- Randomised 10k vectors, WIDTH ∈ {2,8,16}, with idle gaps and back-to-back starts → product matches a*b on every done; done never coincides with busy.
